// File: rtl/hier_record_serializer_pkg.sv
// rtl/hier_record_serializer_pkg.sv - shared sizes, header layout and FSM states for the record serializer
//
// Purpose: common definitions imported by hier_record_serializer.
// Ports:   none (package).

package hier_record_serializer_pkg;

  localparam int ASIZE  = 7;   // width of header field variablea
  localparam int ASIZE2 = 11;  // default element count and element width
  localparam int HDR_W  = 19;  // total header width

  // Header as it arrives on in_hdr: [18:11] yet_another, [10:7] another, [6:0] variablea.
  typedef struct packed {
    logic [7:0]       yet_another;
    logic [3:0]       another;
    logic [ASIZE-1:0] variablea;
  } hdr_st;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_ELEM = 2'd2
  } state_t;

endpackage

// File: rtl/hier_record_serializer.sv
// rtl/hier_record_serializer.sv - serializes a header plus up to NUM_ELEM elements into output beats
//
// Purpose: accepts one record (header, element array, element count) and emits
//          it as count+1 beats: one header beat followed by one beat per element.
//          A new record can be accepted in the same cycle as the final beat of the
//          previous one, so records stream back to back without a bubble.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    record handshake
//   in_hdr               19-bit header
//   in_elems             NUM_ELEM elements, element k at [k*ELEM_W +: ELEM_W]
//   in_count             number of valid elements (values above NUM_ELEM are clamped)
//   out_valid/out_ready  beat handshake
//   out_data             beat payload, zero-extended to OUT_W
//   out_idx              0 for the header beat, k+1 for element k
//   out_first/out_last   first / final beat of a record
//   err_ovf              sticky flag: an over-long in_count was accepted

module hier_record_serializer
  import hier_record_serializer_pkg::*;
#(
  parameter  int NUM_ELEM = ASIZE2,
  parameter  int ELEM_W   = ASIZE2,
  parameter  int OUT_W    = 24,
  localparam int CW       = $clog2(NUM_ELEM + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [HDR_W-1:0]           in_hdr,
  input  logic [NUM_ELEM*ELEM_W-1:0] in_elems,
  input  logic [CW-1:0]              in_count,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [CW-1:0]              out_idx,
  output logic                       out_first,
  output logic                       out_last,
  output logic                       err_ovf
);

  generate
    if (OUT_W < HDR_W || OUT_W < ELEM_W) begin : g_bad_out_w
      $error("hier_record_serializer: OUT_W must be at least max(HDR_W, ELEM_W)");
    end
    if (NUM_ELEM < 1 || NUM_ELEM > 64) begin : g_bad_num_elem
      $error("hier_record_serializer: NUM_ELEM must be in 1..64");
    end
  endgenerate

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] MAX_CNT = CW'(NUM_ELEM);

  state_t                     state;
  logic [NUM_ELEM*ELEM_W-1:0] elems_q;
  logic [CW-1:0]              count_q;
  logic [CW-1:0]              ptr;

  logic                       beat_done;
  logic                       accept;
  logic                       ovf;
  logic [CW-1:0]              count_clamped;
  logic [CW-1:0]              sel_ptr;
  logic [ELEM_W-1:0]          elem_sel;
  hdr_st                      hdr_in;

  assign beat_done = out_valid && out_ready;

  // The record slot frees up exactly when the final beat of the current
  // record is consumed, which is what lets records run back to back.
  assign in_ready  = (state == ST_IDLE) || (beat_done && out_last);
  assign accept    = in_valid && in_ready;

  assign ovf           = in_count > MAX_CNT;
  assign count_clamped = ovf ? MAX_CNT : in_count;
  assign hdr_in        = hdr_st'(in_hdr);

  // Element that becomes the next beat: element 0 after the header,
  // otherwise the one following the element currently on the output.
  assign sel_ptr  = (state == ST_HDR) ? '0 : ptr + ONE;
  assign elem_sel = elems_q[int'(sel_ptr) * ELEM_W +: ELEM_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      elems_q   <= '0;
      count_q   <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      if (accept && ovf) begin
        err_ovf <= 1'b1;
      end

      if (accept) begin
        // Capture the record and put its header beat on the output right away.
        state     <= ST_HDR;
        elems_q   <= in_elems;
        count_q   <= count_clamped;
        ptr       <= '0;
        out_valid <= 1'b1;
        out_data  <= OUT_W'({hdr_in.yet_another, hdr_in.another, hdr_in.variablea});
        out_idx   <= '0;
        out_first <= 1'b1;
        out_last  <= (count_clamped == '0);
      end else if (beat_done) begin
        if (out_last) begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          out_first <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          state     <= ST_ELEM;
          ptr       <= sel_ptr;
          out_data  <= OUT_W'(elem_sel);
          out_idx   <= sel_ptr + ONE;
          out_first <= 1'b0;
          out_last  <= ((sel_ptr + ONE) == count_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_hier_record_serializer.sv
// tb/tb_hier_record_serializer.sv - self-checking bench for hier_record_serializer

module tb_hier_record_serializer;

  localparam int NE  = 11;
  localparam int EW  = 11;
  localparam int OW  = 24;
  localparam int CW  = $clog2(NE + 1);
  localparam int HW  = 19;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [HW-1:0]       in_hdr;
  logic [NE*EW-1:0]    in_elems;
  logic [CW-1:0]       in_count;
  logic                out_valid;
  logic                out_ready;
  logic [OW-1:0]       out_data;
  logic [CW-1:0]       out_idx;
  logic                out_first;
  logic                out_last;
  logic                err_ovf;

  always #5 clk = ~clk;

  hier_record_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_hdr    (in_hdr),
    .in_elems  (in_elems),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_first (out_first),
    .out_last  (out_last),
    .err_ovf   (err_ovf)
  );

  typedef struct {
    logic [OW-1:0] data;
    int            idx;
    bit            first;
    bit            last;
  } beat_t;

  beat_t         exp_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            accepted;
  bit            lat_pending = 0;
  bit            rand_ready = 0;
  bit            prev_stall = 0;
  logic [OW-1:0] prev_data;
  logic [CW-1:0] prev_idx;
  logic          prev_first;
  logic          prev_last;
  int            run_len = 0;
  int            last_run = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NE*EW-1:0] rand_elems();
    logic [NE*EW-1:0] v;
    v = '0;
    for (int k = 0; k < NE; k++) v[k*EW +: EW] = EW'($urandom);
    return v;
  endfunction

  // Expected beat list of a record: header first, then each element in order.
  task automatic push_model(input logic [HW-1:0] hdr, input logic [NE*EW-1:0] elems,
                            input int cnt);
    int    n;
    beat_t b;
    n = (cnt > NE) ? NE : cnt;
    b.data = OW'(hdr); b.idx = 0; b.first = 1; b.last = (n == 0);
    exp_q.push_back(b);
    for (int k = 0; k < n; k++) begin
      b.data = OW'(elems[k*EW +: EW]); b.idx = k + 1; b.first = 0; b.last = (k == n - 1);
      exp_q.push_back(b);
    end
  endtask

  // One clock cycle: observe both channels at the falling edge, then return 1 after the rising edge.
  task automatic cyc();
    beat_t e;
    @(negedge clk);
    if (lat_pending && rst_n) begin
      chk("latency_out_valid", out_valid, 1);
      chk("latency_out_first", out_first, 1);
      chk("latency_out_idx", out_idx, 0);
    end
    lat_pending = 0;
    if (prev_stall && rst_n) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, prev_data);
      chk("stall_out_idx", out_idx, prev_idx);
      chk("stall_out_first", out_first, prev_first);
      chk("stall_out_last", out_last, prev_last);
    end
    accepted = 0;
    if (rst_n && in_valid && in_ready) begin
      push_model(in_hdr, in_elems, int'(in_count));
      accepted = 1;
      lat_pending = 1;
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("beat_without_record", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", out_data, e.data);
        chk("beat_idx", out_idx, e.idx);
        chk("beat_first", out_first, e.first);
        chk("beat_last", out_last, e.last);
        if (e.last) chk("in_ready_on_last", in_ready, 1);
      end
      run_len++;
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
    prev_stall = rst_n && out_valid && !out_ready;
    prev_data  = out_data;
    prev_idx   = out_idx;
    prev_first = out_first;
    prev_last  = out_last;
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [HW-1:0] hdr, input logic [NE*EW-1:0] elems,
                      input logic [CW-1:0] cnt);
    in_hdr   = hdr;
    in_elems = elems;
    in_count = cnt;
    in_valid = 1;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (accepted) break;
    end
    if (!accepted) chk("send_timeout_in_ready", in_ready, 1);
    // Junk on the inputs while nothing is offered must not reach the output.
    in_valid = 0;
    in_hdr   = HW'($urandom);
    in_elems = rand_elems();
    in_count = CW'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      cyc();
    end
    chk("drain_pending_beats", exp_q.size(), 0);
    cyc();
  endtask

  initial begin
    logic [HW-1:0] hdr;
    rst_n = 0; in_valid = 0; out_ready = 0;
    in_hdr = '0; in_elems = '0; in_count = '0;
    repeat (3) cyc();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_idx", out_idx, 0);
    chk("reset_out_first", out_first, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_err_ovf", err_ovf, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1;
    out_ready = 1;
    cyc();

    // Directed header example: three beats, header value built from its fields.
    hdr = HW'((8'hA5 << 11) | (4'h3 << 7) | 7'h12);
    chk("example_header_value", 64'(hdr), 64'h052992);
    send(hdr, rand_elems(), CW'(2));
    drain();
    chk("example_run_length", last_run, 3);

    // Empty record followed immediately by another: header-only beat, then no gap.
    send(HW'($urandom), rand_elems(), CW'(0));
    send(HW'($urandom), rand_elems(), CW'(2));
    drain();
    chk("count0_back_to_back_run", last_run, 4);

    // Two full records back to back: 24 beats with no bubble.
    send(HW'($urandom), rand_elems(), CW'(NE));
    send(HW'($urandom), rand_elems(), CW'(NE));
    drain();
    chk("full_back_to_back_run", last_run, 24);

    // Random records under random back-pressure.
    rand_ready = 1;
    for (int r = 0; r < 25; r++) begin
      send(HW'($urandom), rand_elems(), CW'($urandom_range(0, NE)));
      repeat ($urandom_range(0, 3)) cyc();
    end
    drain();
    rand_ready = 0;
    out_ready = 1;
    cyc();
    chk("err_ovf_before_overflow", err_ovf, 0);

    // Over-long count is clamped and latches the sticky error.
    send(HW'($urandom), rand_elems(), CW'(15));
    drain();
    chk("overflow_run_length", last_run, 12);
    chk("overflow_err_ovf", err_ovf, 1);
    send(HW'($urandom), rand_elems(), CW'(3));
    drain();
    chk("overflow_err_ovf_sticky", err_ovf, 1);

    // Reset in the middle of element beat 5 discards the record.
    send(HW'($urandom), rand_elems(), CW'(NE));
    for (int i = 0; i < 50; i++) begin
      if (out_valid && out_idx == CW'(6)) break;
      cyc();
    end
    chk("mid_record_reached_idx", out_idx, 6);
    rst_n = 0;
    cyc();
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_idx", out_idx, 0);
    chk("midreset_err_ovf", err_ovf, 0);
    exp_q.delete();
    rst_n = 1;
    cyc();
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);

    // Normal operation after reset.
    send(HW'($urandom), rand_elems(), CW'(4));
    drain();
    chk("post_reset_run_length", last_run, 5);
    chk("post_reset_err_ovf", err_ovf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hier_record_serializer.md
HIER_RECORD_SERIALIZER -- requirements
Module: hier_record_serializer

Interface
REQ-001 Parameter NUM_ELEM, default 11 (ASIZE2): element slots per record, range 1..64, SHALL be honoured.
REQ-002 Parameter ELEM_W, default 11 (aBiggerT width): bits per element, SHALL be honoured.
REQ-003 Parameter OUT_W, default 24: output beat width, SHALL satisfy OUT_W >= max(19, ELEM_W), checked at elaboration.
REQ-004 clk  input  1  sole clock; all logic SHALL be rising-edge clk.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  record offered.
REQ-007 in_ready  output  1  record accepted when in_valid && in_ready.
REQ-008 in_hdr  input  19  header: [6:0] variablea (aSizeT), [10:7] another (anotherSizeT), [18:11] yetAnother (yetAnotherSizeT).
REQ-009 in_elems  input  NUM_ELEM*ELEM_W  element k at [k*ELEM_W +: ELEM_W].
REQ-010 in_count  input  CW=$clog2(NUM_ELEM+1)  number of valid elements, 0..NUM_ELEM.
REQ-011 out_valid  output  1  beat present.
REQ-012 out_ready  input  1  beat consumed when out_valid && out_ready.
REQ-013 out_data  output  OUT_W  beat payload, zero-extended.
REQ-014 out_idx  output  CW  0 = header beat, k+1 = element k.
REQ-015 out_first / out_last  output  1 each  first / final beat of record.
REQ-016 err_ovf  output  1  sticky: a record with in_count > NUM_ELEM was accepted.

Function
REQ-017 FSM states IDLE, HDR, ELEM SHALL be used; reset state IDLE.
REQ-018 in_ready SHALL be 1 in IDLE, and in HDR/ELEM only in a cycle where out_valid && out_ready && out_last (zero-bubble back-to-back).
REQ-019 On acceptance, in_hdr, in_elems and clamped count min(in_count, NUM_ELEM) SHALL be registered; state -> HDR next cycle.
REQ-020 Latency: record accepted at edge t SHALL present its header beat (out_valid=1) in the cycle after t.
REQ-021 HDR: out_data = zero-extended header, out_idx=0, out_first=1, out_last = (count==0).
REQ-022 HDR on handshake: count==0 -> IDLE (or HDR if a new record accepted same cycle); else -> ELEM with element pointer 0.
REQ-023 ELEM: out_data = element[ptr] zero-extended, out_idx=ptr+1, out_first=0, out_last=(ptr==count-1).
REQ-024 ELEM on handshake: ptr increments; on last beat -> IDLE, or HDR if a new record accepted same cycle.
REQ-025 While out_valid && !out_ready, out_data, out_idx, out_first, out_last SHALL hold stable; out_valid SHALL NOT drop without handshake.
REQ-026 in_count > NUM_ELEM SHALL be clamped to NUM_ELEM and set err_ovf, held until reset.
REQ-027 Input data outside an accepted cycle SHALL have no effect on output.
REQ-028 Throughput: a record of count c SHALL occupy exactly c+1 output beats with out_ready held high.

Reset
REQ-029 While rst_n=0 at an edge: state IDLE, out_valid=0, out_data=0, out_idx=0, out_first=0, out_last=0, err_ovf=0, ptr=0.
REQ-030 Reset mid-record SHALL discard the record; first cycle after release in_ready=1, out_valid=0.

Structure
REQ-031 Shared package SHALL hold ASIZE=7, ASIZE2=11, HDR_W=19, header struct hdrSt {yetAnother, another, variablea}, FSM state enum.
REQ-032 No sub-module; element select SHALL be an inline indexed part-select on the captured register.

Verification
REQ-033 Defaults, hdr {yetAnother=8'hA5, another=4'h3, variablea=7'h12}, count=2, out_ready=1 -> beats: idx0 data 24'h052992 first=1; idx1 elem0; idx2 elem1 last=1; in_ready=1 on the last beat.
REQ-034 count=0 -> single header beat with out_first=out_last=1; next record accepted same cycle, header next cycle.
REQ-035 Two back-to-back records count=11, out_ready=1 -> 24 consecutive valid beats, no bubble.
REQ-036 out_ready toggled randomly -> every beat stable while stalled, order idx 0..count preserved, no beat lost or duplicated.
REQ-037 in_count=15 (NUM_ELEM=11) -> 12 beats emitted, err_ovf=1 and remains 1 until rst_n=0.
REQ-038 rst_n=0 during ELEM beat 5 -> out_valid=0 next cycle, in_ready=1 after release, err_ovf=0.
